ram_march_bist: RTL and testbench
=================================

// Module: ram_march_bist
// PURPOSE
//  Built-in self-test initiator for the single-port synchronous byte RAM. Drives the RAM port
//  (we/addr/data_in) and checks data_out. Runs a 4-element March sequence over every address,
//  counts mismatches and captures the first failing address.
//  Sits beside the RAM and owns its port while busy. System muxing is outside this block.
// PARAMETERS
//  ADDR_W   20     RAM address width; depth N = 2**ADDR_W
//  DATA_W   8      RAM data width
//  PATTERN  8'h55  background word P (DATA_W bits); complement ~P used as second pattern
//  ERR_W    16     width of error counter (saturating)
// PORTS
//  clk        in   1        rising-edge clock shared with RAM
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        start request; sampled only in IDLE
//  busy       out  1        test in progress
//  done       out  1        one-cycle pulse at test completion
//  pass       out  1        1 = last completed run had zero mismatches; held until next start
//  err_count  out  ERR_W    mismatches in current/last run, saturates at all-ones
//  fail_addr  out  ADDR_W   address of first mismatch in run (0 if none)
//  ram_we     out  1        to RAM write enable
//  ram_addr   out  ADDR_W   to RAM address
//  ram_wdata  out  DATA_W   to RAM write data
//  ram_rdata  in   DATA_W   from RAM registered read data (valid 1 cycle after addr; read-during-write returns old word)
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0 (ram_we=0 immediately); RAM contents left undefined.
//  All outputs are registered. start is ignored when not IDLE. Reset mid-run aborts with no done pulse.
//  States: IDLE -> W0 -> RW1 -> RW0 -> RD -> DRAIN -> IDLE.
//  IDLE : busy=0, ram_we=0. start=1 at an edge -> W0, addr=0, err_count=0, fail_addr=0, pass=0.
//  W0   : ascending 0..N-1, one cycle/addr: we=1, wdata=P.
//  RW1  : ascending. Two cycles/addr: cycle A (read, we=0), cycle B (same addr, we=1, wdata=~P).
//         During B, compare ram_rdata with P.
//  RW0  : descending N-1..0. Same A/B pairing: expect ~P, write P.
//  RD   : ascending, one read/cycle, we=0. ram_rdata from previous cycle's addr is compared with P.
//         Compare address pipelined one stage.
//  DRAIN: one cycle, we=0, compares last RD read (addr N-1). -> IDLE.
//  Counts: W0 N + RW1 2N + RW0 2N + RD N + DRAIN 1. busy high exactly 6N+1 cycles.
//  At the DRAIN->IDLE edge: done=1 for one cycle, busy=0, pass=(err_count==0 incl. DRAIN compare).
//  Mismatch: err_count += 1 unless all-ones (saturate).
//         If it is the first mismatch of the run, fail_addr = compared address.
//  Phase transitions: on the last address of a phase (N-1 ascending, 0 descending), the address
//         counter wraps to next phase start with no idle cycle.
//  ram_addr/ram_wdata hold last values in IDLE, ram_we=0. wdata don't-care in read cycles; drive 0.
//  start asserted in the done cycle is accepted (state is IDLE): new run begins next cycle.
// TESTING (bench uses ADDR_W=4, N=16, behavioural 1-cycle-latency RAM model)
//  1 Clean RAM, pulse start -> busy high 97 cycles, done pulse once, pass=1, err_count=0, fail_addr=0.
//  2 Model bit1 of addr 5 stuck-at-1 -> 2 mismatches (RW1 and RD reads of P=0x55).
//    err_count=2, fail_addr=5, pass=0.
//  3 Monitor port in RW0 -> ram_addr 15,15,14,14..0,0; ram_we 0,1 alternating.
//    wdata=0x55 on writes; W0 writes 0x55, RW1 writes 0xAA.
//  4 Hold start high for whole run -> no restart while busy.
//    New run starts cycle after done pulse; second result identical to first.
//  5 Assert rst at cycle 30 of a run -> same-cycle ram_we=0, busy=0, all outputs 0, no done.
//    Re-start after release -> clean 97-cycle pass.
//  6 ERR_W=2, stuck-at faults at 3 and 9 (bit1 high) -> err_count saturates at 3, fail_addr=3, pass=0.

Source files
------------

// File: rtl/ram_march_bist_if.sv
// Port bundle between the March BIST engine, whoever starts it, and the RAM under test.
interface ram_march_bist_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8,
    parameter int ERR_W  = 16
);
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] fail_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        input  start, ram_rdata,
        output busy, done, pass, err_count, fail_addr, ram_we, ram_addr, ram_wdata
    );
    modport slave (
        output start, ram_rdata,
        input  busy, done, pass, err_count, fail_addr, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_march_bist.sv
// March BIST initiator: W0(P), up R(P)W(~P), down R(~P)W(P), up R(P), then a drain compare.
// Counts mismatches (saturating) and records the first failing address of each run.
module ram_march_bist #(
    parameter int                ADDR_W  = 20,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'h55,
    parameter int                ERR_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    ram_march_bist_if.master bus
);
    typedef enum logic [2:0] {IDLE, W0, RW1, RW0, RD, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              sub, sub_n;        // 0 = read half, 1 = write half of an RW pair
    logic              rd_vld;
    logic [ADDR_W-1:0] rd_addr;
    logic              we, we_n;
    logic [DATA_W-1:0] wdata, wdata_n;
    logic              busy, done, pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] fail_addr;
    logic              cmp_en, mismatch;
    logic [DATA_W-1:0] expect_data;
    logic [ADDR_W-1:0] cmp_addr;

    always_comb begin
        state_n = state;
        addr_n  = addr;
        sub_n   = 1'b0;
        we_n    = 1'b0;
        wdata_n = '0;
        case (state)
            IDLE: if (bus.start) begin
                state_n = W0;
                addr_n  = '0;
            end
            W0: if (addr == ADDR_LAST) begin
                state_n = RW1;
                addr_n  = '0;
            end else begin
                addr_n = addr + 1'b1;
            end
            RW1: if (!sub) begin
                sub_n = 1'b1;
            end else if (addr == ADDR_LAST) begin
                state_n = RW0;
                addr_n  = ADDR_LAST;
            end else begin
                addr_n = addr + 1'b1;
            end
            RW0: if (!sub) begin
                sub_n = 1'b1;
            end else if (addr == '0) begin
                state_n = RD;
                addr_n  = '0;
            end else begin
                addr_n = addr - 1'b1;
            end
            RD: if (addr == ADDR_LAST) begin
                state_n = DRAIN;
            end else begin
                addr_n = addr + 1'b1;
            end
            DRAIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Port drive is derived from the upcoming state so it lands registered with it
        case (state_n)
            W0:  begin we_n = 1'b1; wdata_n = PATTERN; end
            RW1: if (sub_n) begin we_n = 1'b1; wdata_n = ~PATTERN; end
            RW0: if (sub_n) begin we_n = 1'b1; wdata_n = PATTERN; end
            default: ;
        endcase
    end

    // RW compares happen in the write half, when the read half's data has returned
    always_comb begin
        cmp_en      = 1'b0;
        expect_data = PATTERN;
        cmp_addr    = addr;
        if ((state == RW1 || state == RW0) && sub) begin
            cmp_en      = 1'b1;
            expect_data = (state == RW1) ? PATTERN : ~PATTERN;
        end
        if (rd_vld) begin
            cmp_en   = 1'b1;
            cmp_addr = rd_addr;
        end
        mismatch = cmp_en && (bus.ram_rdata != expect_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            sub       <= 1'b0;
            rd_vld    <= 1'b0;
            rd_addr   <= '0;
            we        <= 1'b0;
            wdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            sub     <= sub_n;
            rd_vld  <= (state == RD);
            rd_addr <= addr;
            we      <= we_n;
            wdata   <= wdata_n;
            busy    <= (state_n != IDLE);
            done    <= (state == DRAIN);
            if (state == IDLE && bus.start) begin
                err_count <= '0;
                fail_addr <= '0;
                pass      <= 1'b0;
            end else if (mismatch) begin
                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                // counter saturates rather than wraps, so zero means no earlier failure
                if (err_count == '0) fail_addr <= cmp_addr;
            end
            if (state == DRAIN) pass <= (err_count == '0) && !mismatch;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.err_count = err_count;
    assign bus.fail_addr = fail_addr;
    assign bus.ram_we    = we;
    assign bus.ram_addr  = addr;
    assign bus.ram_wdata = wdata;
endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: 16-word RAM models with stuck-at-1 masks, a run-level model
// of the March port sequence and result, and directed scenarios.
module tb_ram_march_bist;
    localparam logic [7:0] P  = 8'h55;
    localparam logic [7:0] AP = 8'hAA;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ram_march_bist_if #(.ADDR_W(4), .DATA_W(8), .ERR_W(16)) a_if ();
    ram_march_bist_if #(.ADDR_W(4), .DATA_W(8), .ERR_W(2))  b_if ();

    ram_march_bist #(.ADDR_W(4), .DATA_W(8), .PATTERN(8'h55), .ERR_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if));
    ram_march_bist #(.ADDR_W(4), .DATA_W(8), .PATTERN(8'h55), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if));

    // RAMs: registered read of the old word; masks force bits to 1 on the read path
    logic [7:0]        mem_a [16];
    logic [7:0]        mem_b [16];
    logic [15:0][7:0]  mask_a;
    logic [15:0][7:0]  mask_b;

    always @(posedge clk) begin
        a_if.ram_rdata <= mem_a[a_if.ram_addr] | mask_a[a_if.ram_addr];
        if (a_if.ram_we) mem_a[a_if.ram_addr] <= a_if.ram_wdata;
        b_if.ram_rdata <= mem_b[b_if.ram_addr] | mask_b[b_if.ram_addr];
        if (b_if.ram_we) mem_b[b_if.ram_addr] <= b_if.ram_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected port activity at cycle k of a run (k = 0 .. 96); ad < 0 means not checked
    function automatic void model_port(input int k, output bit we, output int ad, output int wd);
        int j;
        we = 1'b0; ad = -1; wd = 0;
        if (k < 16) begin
            we = 1'b1; ad = k; wd = P;
        end else if (k < 48) begin
            j = k - 16; ad = j / 2; we = (j % 2) == 1; wd = we ? AP : 0;
        end else if (k < 80) begin
            j = k - 48; ad = 15 - j / 2; we = (j % 2) == 1; wd = we ? P : 0;
        end else if (k < 96) begin
            ad = k - 80;
        end
    endfunction

    // Expected run result: reads in March order, data returned is the written word OR mask
    function automatic void model_result(input logic [15:0][7:0] m, input int maxv,
                                         output int cnt, output int fa);
        int ad;
        logic [7:0] e;
        cnt = 0; fa = 0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                ad = (p == 1) ? 15 - i : i;
                e  = (p == 1) ? AP : P;
                if ((e | m[ad]) != e) begin
                    if (cnt == 0) fa = ad;
                    if (cnt < maxv) cnt++;
                end
            end
        end
    endfunction

    int run_k    = -1;
    bit exp_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_k = -1; exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (run_k < 0) begin
                if (a_if.start) run_k = 0;
            end else if (run_k == 96) begin
                run_k = -1; exp_done = 1'b1;
            end else begin
                run_k++;
            end
        end
    end

    int         busy_cnt = 0;
    int         done_cnt = 0;
    bit         tr_we   [97];
    int         tr_addr [97];
    logic [7:0] tr_wd   [97];

    always @(negedge clk) begin
        if (!rst) begin
            bit mw;
            int ma, md, ec, ef;
            chk("busy", a_if.busy, run_k >= 0);
            chk("done", a_if.done, exp_done);
            if (a_if.busy) busy_cnt++;
            if (a_if.done) done_cnt++;
            if (run_k >= 0) begin
                model_port(run_k, mw, ma, md);
                chk("ram_we", a_if.ram_we, mw);
                if (ma >= 0) chk("ram_addr", a_if.ram_addr, ma);
                chk("ram_wdata", a_if.ram_wdata, md);
                tr_we[run_k]   = a_if.ram_we;
                tr_addr[run_k] = a_if.ram_addr;
                tr_wd[run_k]   = a_if.ram_wdata;
            end else begin
                chk("ram_we_idle", a_if.ram_we, 0);
            end
            if (exp_done) begin
                model_result(mask_a, 65535, ec, ef);
                chk("err_count", a_if.err_count, ec);
                chk("fail_addr", a_if.fail_addr, ef);
                chk("pass", a_if.pass, ec == 0);
            end
        end
    end

    task automatic wait_done_a(output int n);
        n = 0;
        while (!a_if.done && n < 300) begin @(negedge clk); n++; end
        chk("a_done_within_bound", a_if.done, 1);
    endtask

    task automatic run_a();
        int n;
        busy_cnt = 0; done_cnt = 0;
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        wait_done_a(n);
        @(negedge clk);
    endtask

    initial begin
        int n, ec, ef;
        int sk [8] = '{0, 16, 17, 48, 49, 50, 79, 80};
        int sa [8] = '{0, 0, 0, 15, 15, 14, 0, 0};
        bit sw [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int sd [8] = '{8'h55, 0, 8'hAA, 0, 8'h55, 0, 8'h55, 0};

        rst = 1'b1; a_if.start = 1'b0; b_if.start = 1'b0;
        mask_a = '0; mask_b = '0;
        for (int i = 0; i < 16; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end
        repeat (3) @(negedge clk);
        chk("rst_busy", a_if.busy, 0);
        chk("rst_we", a_if.ram_we, 0);
        chk("rst_err", a_if.err_count, 0);
        chk("rst_pass", a_if.pass, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: clean run
        run_a();
        chk("t1_busy_cycles", busy_cnt, 97);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_pass", a_if.pass, 1);
        chk("t1_err", a_if.err_count, 0);
        chk("t1_fail_addr", a_if.fail_addr, 0);
        for (int i = 0; i < 8; i++) begin
            chk("t3_trace_we", tr_we[sk[i]], sw[i]);
            chk("t3_trace_addr", tr_addr[sk[i]], sa[i]);
            chk("t3_trace_wdata", tr_wd[sk[i]], sd[i]);
        end

        // 2: bit1 of address 5 stuck at 1
        mask_a[5] = 8'h02;
        run_a();
        chk("t2_err", a_if.err_count, 2);
        chk("t2_fail_addr", a_if.fail_addr, 5);
        chk("t2_pass", a_if.pass, 0);
        chk("t2_busy_cycles", busy_cnt, 97);

        // 4: start held high across a whole run
        mask_a = '0;
        a_if.start = 1'b1;
        @(negedge clk);
        wait_done_a(n);
        chk("t4_first_pass", a_if.pass, 1);
        @(negedge clk);
        chk("t4_restart_busy", a_if.busy, 1);
        chk("t4_restart_addr", a_if.ram_addr, 0);
        wait_done_a(n);
        a_if.start = 1'b0;
        chk("t4_restart_period", n + 1, 98);
        chk("t4_second_pass", a_if.pass, 1);
        chk("t4_second_err", a_if.err_count, 0);
        @(negedge clk);
        chk("t4_no_third_run", a_if.busy, 0);

        // 5: reset in the middle of a run
        done_cnt = 0;
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (29) @(negedge clk);
        chk("t5_busy_before_rst", a_if.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_we", a_if.ram_we, 0);
        chk("t5_rst_busy", a_if.busy, 0);
        chk("t5_rst_done", a_if.done, 0);
        chk("t5_rst_addr", a_if.ram_addr, 0);
        chk("t5_rst_wdata", a_if.ram_wdata, 0);
        chk("t5_rst_err", a_if.err_count, 0);
        chk("t5_rst_fail", a_if.fail_addr, 0);
        repeat (4) @(negedge clk);
        chk("t5_no_done", done_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        run_a();
        chk("t5_busy_cycles", busy_cnt, 97);
        chk("t5_pass", a_if.pass, 1);

        // 6: narrow saturating counter, two faulty addresses
        mask_b[3] = 8'h02; mask_b[9] = 8'h02;
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        n = 0;
        while (!b_if.done && n < 300) begin @(negedge clk); n++; end
        chk("b_done_within_bound", b_if.done, 1);
        chk("t6_err", b_if.err_count, 3);
        chk("t6_fail_addr", b_if.fail_addr, 3);
        chk("t6_pass", b_if.pass, 0);
        model_result(mask_b, 3, ec, ef);
        chk("t6_err_model", b_if.err_count, ec);
        chk("t6_fail_model", b_if.fail_addr, ef);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
